// File: rtl/forward_sequencer.sv
// Admission and mode scheduler for a forward MAC layer.
// Gates State0 samples into the layer, tracks in-flight samples, and sequences TRAIN/TEST changes and weight-update barriers.
module forward_sequencer #(
  parameter int DEPTH = 8,
  parameter int NS    = 16,
  parameter int WIDTH = 35
) (
  input  logic                         iCLK,
  input  logic                         iRST,
  input  logic                         iModeReq,
  output logic                         oMode,
  input  logic                         iValid_AS,
  output logic                         oReady_AS,
  input  logic [WIDTH-1:0]             iData_AS,
  output logic                         oValid_BM,
  input  logic                         iReady_BM,
  output logic [WIDTH-1:0]             oData_BM,
  input  logic                         iValid_Ret,
  input  logic                         iReady_Ret,
  output logic                         oUpdateReq,
  input  logic                         iUpdateAck,
  output logic [$clog2(DEPTH+1)-1:0]   oCount,
  output logic                         oError
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(NS + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [BW-1:0] BLAST   = BW'(NS - 1);
  localparam logic MODE_TEST  = 1'b0;
  localparam logic MODE_TRAIN = 1'b1;

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_APPLY,
    S_BARRIER
  } state_t;

  state_t        state_q, state_d;
  logic          mode_q, mode_d;
  logic [CW-1:0] count_q, count_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          error_q, error_d;
  logic          gate;
  logic          admit;
  logic          retire;
  logic          last_of_batch;

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state_q <= S_RUN;
      mode_q  <= MODE_TEST;
      count_q <= '0;
      bcnt_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      bcnt_q  <= bcnt_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    bcnt_d        = bcnt_q;
    count_d       = count_q;
    error_d       = error_q | (retire && (count_q == '0));
    last_of_batch = (mode_q == MODE_TRAIN) && admit && (bcnt_q == BLAST);

    // A retirement with nothing in flight is flagged, never wrapped.
    if (admit && !retire) begin
      count_d = count_q + CW'(1);
    end else if (retire && !admit && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end

    case (state_q)
      S_RUN: begin
        if (last_of_batch) begin
          state_d = S_BARRIER;
        end else if (iModeReq != mode_q) begin
          state_d = S_DRAIN;
        end
        if ((mode_q == MODE_TRAIN) && admit && !last_of_batch) begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
      S_DRAIN: begin
        if (count_d == '0) begin
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        mode_d  = iModeReq;
        bcnt_d  = '0;
        state_d = S_RUN;
      end
      S_BARRIER: begin
        if ((count_q == '0) && iUpdateAck) begin
          bcnt_d  = '0;
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    gate       = (state_q == S_RUN) && (count_q < DEPTH_C);
    admit      = iValid_AS && iReady_BM && gate;
    retire     = iValid_Ret && iReady_Ret;
    oValid_BM  = iValid_AS && gate;
    oReady_AS  = iReady_BM && gate;
    oData_BM   = iData_AS;
    oUpdateReq = (state_q == S_BARRIER) && (count_q == '0);
    oMode      = mode_q;
    oCount     = count_q;
    oError     = error_q;
  end

endmodule

// File: tb/tb_forward_sequencer.sv
// Directed bench for forward_sequencer: stimulus queues expected admissions and status,
// a negedge monitor pops and compares them.
module tb_forward_sequencer;

  localparam int DEPTH = 8;
  localparam int NS    = 16;
  localparam int WIDTH = 35;

  logic             iCLK = 1'b0;
  logic             iRST;
  logic             iModeReq;
  logic             oMode;
  logic             iValid_AS;
  logic             oReady_AS;
  logic [WIDTH-1:0] iData_AS;
  logic             oValid_BM;
  logic             iReady_BM;
  logic [WIDTH-1:0] oData_BM;
  logic             iValid_Ret;
  logic             iReady_Ret;
  logic             oUpdateReq;
  logic             iUpdateAck;
  logic [3:0]       oCount;
  logic             oError;

  always #5 iCLK = ~iCLK;

  forward_sequencer #(.DEPTH(DEPTH), .NS(NS), .WIDTH(WIDTH)) dut (
    .iCLK(iCLK), .iRST(iRST), .iModeReq(iModeReq), .oMode(oMode),
    .iValid_AS(iValid_AS), .oReady_AS(oReady_AS), .iData_AS(iData_AS),
    .oValid_BM(oValid_BM), .iReady_BM(iReady_BM), .oData_BM(oData_BM),
    .iValid_Ret(iValid_Ret), .iReady_Ret(iReady_Ret),
    .oUpdateReq(oUpdateReq), .iUpdateAck(iUpdateAck),
    .oCount(oCount), .oError(oError)
  );

  // Status selectors
  localparam int S_CNT = 0, S_MODE = 1, S_ERR = 2, S_RDY = 3, S_UPD = 4, S_VLD = 5, S_PEND = 6;

  typedef struct {
    int    sel;
    int    exp;
    string name;
  } st_t;

  int               checks   = 0;
  int               failures = 0;
  int               tag      = 0;
  logic [WIDTH-1:0] data_q[$];
  st_t              st_q[$];
  logic [WIDTH-1:0] mon_e;
  st_t              mon_s;
  int               mon_a;

  task automatic expect_st(input int sel, input int exp, input string name);
    st_t s;
    s.sel  = sel;
    s.exp  = exp;
    s.name = name;
    st_q.push_back(s);
  endtask

  function automatic int actual(input int sel);
    case (sel)
      S_CNT:   return int'(oCount);
      S_MODE:  return int'(oMode);
      S_ERR:   return int'(oError);
      S_RDY:   return int'(oReady_AS);
      S_UPD:   return int'(oUpdateReq);
      S_VLD:   return int'(oValid_BM);
      S_PEND:  return data_q.size();
      default: return -1;
    endcase
  endfunction

  task automatic step(input logic v, input logic rdy, input logic ret, input logic ack, input logic adm);
    @(posedge iCLK);
    #1;
    tag++;
    iValid_AS  = v;
    iReady_BM  = rdy;
    iValid_Ret = ret;
    iReady_Ret = ret;
    iUpdateAck = ack;
    iData_AS   = {3'b101, 32'(tag)};
    if (adm) data_q.push_back(iData_AS);
  endtask

  task automatic steps(input int n, input logic v, input logic rdy, input logic ret, input logic ack,
                       input logic adm);
    for (int i = 0; i < n; i++) step(v, rdy, ret, ack, adm);
  endtask

  // Monitor: compares admissions and queued status expectations away from the active edge.
  initial begin
    forever begin
      @(negedge iCLK);
      if (oValid_BM && iReady_BM) begin
        checks++;
        if (data_q.size() == 0) begin
          failures++;
          $display("FAIL admit_data: got unexpected admission data=%0h required none", oData_BM);
        end else begin
          mon_e = data_q.pop_front();
          if (oData_BM !== mon_e) begin
            failures++;
            $display("FAIL admit_data: got %0h required %0h", oData_BM, mon_e);
          end
        end
      end
      while (st_q.size() > 0) begin
        mon_s = st_q.pop_front();
        mon_a = actual(mon_s.sel);
        checks++;
        if (mon_a != mon_s.exp) begin
          failures++;
          $display("FAIL %s: got %0d required %0d", mon_s.name, mon_a, mon_s.exp);
        end
      end
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout: got no completion required completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    iRST = 1'b0; iModeReq = 1'b0; iValid_AS = 1'b0; iReady_BM = 1'b0;
    iValid_Ret = 1'b0; iReady_Ret = 1'b0; iUpdateAck = 1'b0; iData_AS = '0;
    repeat (2) @(posedge iCLK);
    #1 iRST = 1'b1;
    expect_st(S_CNT, 0, "rst_count"); expect_st(S_MODE, 0, "rst_mode");
    expect_st(S_ERR, 0, "rst_err");   expect_st(S_UPD, 0, "rst_upd");

    // TEST mode, retire stalled: only DEPTH samples get through
    step(1, 1, 0, 0, 1); expect_st(S_RDY, 1, "open_after_rst");
    steps(7, 1, 1, 0, 0, 1);
    step(1, 1, 0, 0, 0); expect_st(S_RDY, 0, "full_ready"); expect_st(S_VLD, 0, "full_valid");
    step(1, 1, 0, 0, 0); expect_st(S_CNT, 8, "full_count");
    step(1, 1, 1, 0, 0);
    step(1, 1, 0, 0, 1); expect_st(S_CNT, 7, "after_ret_count");
    step(0, 1, 0, 0, 0); expect_st(S_CNT, 8, "refill_count"); expect_st(S_PEND, 0, "pend_a");

    // Simultaneous admit/retire, then underflow
    steps(5, 0, 1, 1, 0, 0);
    step(1, 1, 1, 0, 1); expect_st(S_CNT, 3, "simul_pre");
    step(0, 1, 0, 0, 0); expect_st(S_CNT, 3, "simul_post");
    steps(3, 0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 0); expect_st(S_CNT, 0, "underflow_pre"); expect_st(S_ERR, 0, "err_pre");
    step(0, 1, 0, 0, 0); expect_st(S_CNT, 0, "underflow_count"); expect_st(S_ERR, 1, "err_set");

    // Mode switch TEST -> TRAIN with 4 in flight
    steps(4, 1, 1, 0, 0, 1);
    step(0, 1, 0, 0, 0); iModeReq = 1'b1; expect_st(S_CNT, 4, "sw_count");
    step(1, 1, 1, 0, 0); expect_st(S_RDY, 0, "drain_closed"); expect_st(S_MODE, 0, "drain_mode");
    steps(3, 1, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0); expect_st(S_CNT, 0, "apply_count"); expect_st(S_RDY, 0, "apply_closed");
    expect_st(S_MODE, 0, "apply_mode_old");
    step(1, 1, 0, 0, 1); expect_st(S_MODE, 1, "train_mode"); expect_st(S_RDY, 1, "train_open");

    // Batch barrier: 16 admitted, early ack ignored, valid ack reopens
    steps(15, 1, 1, 1, 0, 1);
    step(1, 1, 0, 1, 0); expect_st(S_CNT, 1, "bar_count"); expect_st(S_RDY, 0, "bar_closed");
    expect_st(S_UPD, 0, "bar_upd_early"); expect_st(S_PEND, 0, "batch1_pend");
    step(1, 1, 1, 0, 0); expect_st(S_UPD, 0, "ack_ignored"); expect_st(S_RDY, 0, "ack_ignored_rdy");
    step(1, 1, 0, 1, 0); expect_st(S_UPD, 1, "bar_upd"); expect_st(S_CNT, 0, "bar_count0");
    expect_st(S_RDY, 0, "bar_upd_closed");
    step(1, 1, 0, 0, 1); expect_st(S_UPD, 0, "upd_fall"); expect_st(S_RDY, 1, "reopen");
    steps(15, 1, 1, 1, 0, 1);
    step(1, 1, 1, 0, 0); expect_st(S_RDY, 0, "batch2_closed"); expect_st(S_CNT, 1, "batch2_count");
    expect_st(S_PEND, 0, "batch2_pend");
    step(0, 1, 0, 1, 0); expect_st(S_UPD, 1, "batch2_upd");

    // Collision: TEST request on the 16th TRAIN admission
    step(1, 1, 0, 0, 1); expect_st(S_RDY, 1, "coll_open");
    steps(14, 1, 1, 1, 0, 1);
    step(1, 1, 1, 0, 1); iModeReq = 1'b0;
    step(1, 1, 1, 0, 0); expect_st(S_RDY, 0, "coll_barrier"); expect_st(S_MODE, 1, "coll_mode_train");
    step(0, 1, 0, 1, 0); expect_st(S_UPD, 1, "coll_upd");
    step(0, 1, 0, 0, 0); expect_st(S_UPD, 0, "coll_upd_fall"); expect_st(S_RDY, 1, "coll_run");
    step(1, 1, 0, 0, 0); expect_st(S_RDY, 0, "coll_drain");
    step(1, 1, 0, 0, 0); expect_st(S_RDY, 0, "coll_apply"); expect_st(S_MODE, 1, "coll_apply_mode");
    step(1, 1, 0, 0, 1); expect_st(S_MODE, 0, "coll_test_mode"); expect_st(S_RDY, 1, "coll_test_open");
    steps(19, 1, 1, 1, 0, 1);
    step(0, 1, 0, 0, 0); expect_st(S_CNT, 1, "test_count"); expect_st(S_UPD, 0, "test_no_upd");
    expect_st(S_RDY, 1, "test_no_barrier"); expect_st(S_PEND, 0, "test_pend");

    // Reset in BARRIER with oUpdateReq high
    step(0, 1, 1, 0, 0); iModeReq = 1'b1;
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 1); expect_st(S_MODE, 1, "f_train");
    steps(15, 1, 1, 1, 0, 1);
    step(1, 1, 1, 0, 0); expect_st(S_RDY, 0, "f_barrier");
    step(0, 1, 0, 0, 0); expect_st(S_UPD, 1, "f_upd"); expect_st(S_ERR, 1, "err_sticky");
    iRST = 1'b0; iModeReq = 1'b0;
    step(1, 1, 0, 0, 1); iRST = 1'b1;
    expect_st(S_UPD, 0, "post_rst_upd"); expect_st(S_CNT, 0, "post_rst_count");
    expect_st(S_MODE, 0, "post_rst_mode"); expect_st(S_ERR, 0, "post_rst_err");
    expect_st(S_RDY, 1, "post_rst_open");
    step(0, 1, 0, 0, 0); expect_st(S_CNT, 1, "post_rst_admit"); expect_st(S_PEND, 0, "final_pend");

    repeat (2) @(negedge iCLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
